mul_hilo_ctrl: RTL and testbench
================================

# mul_hilo_ctrl

Issue controller for the CPU's single 32×32 multiplier and owner of the architectural HI/LO registers. It accepts MULT/MULTU/MTHI/MTLO/MFHI/MFLO operations from the execute stage over a valid/ready handshake and drives stable operands into the external registered multiplier. It counts the multiplier latency and commits the 64-bit product to HI/LO. Busy back-pressure enforces HI/LO hazards, and the pipeline flush cancels in-flight work.

## Interface
- MUL_LAT, 1: clock edges from operands presented to `mul_result` valid (≥1).
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  operation offered.
- req_ready  out  1  operation accepted this edge when high with req_valid.
- req_op  in  3  0 MULT, 1 MULTU, 2 MTHI, 3 MTLO, 4 MFHI, 5 MFLO; 6–7 reserved.
- req_a  in  32  multiplicand / MTHI-MTLO data.
- req_b  in  32  multiplier operand.
- flush  in  1  cancel in-flight operation and pending response.
- rsp_valid  out  1  MFHI/MFLO data available.
- rsp_ready  in  1  consumer takes rsp_data.
- rsp_data  out  32  HI or LO value.
- mul_x, mul_y  out  32  registered operands to multiplier.
- mul_signed  out  1  high for MULT.
- mul_result  in  64  product {HI,LO}, valid MUL_LAT edges after operands change.
- hi, lo  out  32  architectural HI/LO.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, MUL_WAIT, RESP. Counter `cnt`, width clog2(MUL_LAT+1).
- req_ready = (state==IDLE) & ~flush.
- IDLE, accept MULT/MULTU: mul_x<=req_a, mul_y<=req_b, mul_signed<=(op==MULT), cnt<=0, go MUL_WAIT.
- IDLE, accept MTHI/MTLO: hi (or lo)<=req_a, stay IDLE.
- IDLE, accept MFHI/MFLO: rsp_data<=hi (or lo), rsp_valid<=1, go RESP.
- IDLE, accept reserved op: consumed, no side effect.
- MUL_WAIT: cnt increments each edge. When cnt==MUL_LAT: {hi,lo}<=mul_result, go IDLE.
- RESP: when rsp_ready, rsp_valid<=0, go IDLE. rsp_data is held stable while rsp_valid.
- flush (any state, takes priority): go IDLE, rsp_valid<=0, no HI/LO write, no accept that edge. Flush on the commit edge (cnt==MUL_LAT) suppresses the commit.
- MFHI/MFLO after MULT is serialized by req_ready low in MUL_WAIT and always returns the new product.
- mul_x/mul_y/mul_signed change only on MULT/MULTU accept and otherwise hold.
- reset: state IDLE, cnt 0; hi, lo, rsp_data, mul_x, mul_y 0; mul_signed, rsp_valid, busy 0; req_ready 1 after reset deasserts. Reset mid-operation abandons the operation with no commit.

## Timing
- MULT accepted at edge E0: hi/lo updated at edge E0+MUL_LAT+1. With the default, hi/lo are visible 2 cycles after accept. req_ready is low for MUL_LAT+1 cycles.
- MTHI/MTLO: hi/lo visible the cycle after the accept edge. Back-to-back accepts are allowed.
- MFHI/MFLO accepted at E0: rsp_valid high from E0. Earliest re-accept is the cycle after the rsp handshake edge.
- The product passes through unchanged, with no width adjustment. Sign/zero extension is the multiplier's job, driven by mul_signed.

## Structure
- Package `mul_ctrl_pkg`: op encodings (OP_MULT…OP_MFLO), state enum, MUL_LAT default.
- Sub-module `hilo_reg`: HI/LO pair with separate hi_we/lo_we plus a 64-bit joint write port. It resets to 0.
- The FSM, counter and operand registers sit in the top level. The multiplier instance sits outside, in the execute stage.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 → mul_signed=1. hi=0xFFFFFFFF, lo=0xFFFFFFFA at E0+2. req_ready low for 2 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then MFHI → rsp_data=0xFFFFFFFE, rsp_valid held 3 cycles with rsp_ready low, then it clears.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → both accepted without stall. MFLO returns 0x9ABCDEF0.
- MULT 5×7 with flush on the commit cycle → hi/lo keep prior values (0x0/0x0 after reset). The controller is IDLE the next cycle.
- flush with req_valid in IDLE → req_ready=0, no state change. Flush during RESP → rsp_valid drops next edge.
- reset asserted in MUL_WAIT → all outputs 0 next edge. A later MULT 2×3 yields lo=6, hi=0.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the multiplier issue controller: operation codes,
// controller states and the default multiplier latency.
package mul_ctrl_pkg;

  localparam int MUL_LAT_DEFAULT = 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MTLO  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_RESP     = 2'd2
  } state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair: independent single-word writes for
// MTHI/MTLO and a joint 64-bit write for multiply commits.
module hilo_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        hilo_we,
  input  logic [63:0] hilo_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_we) begin
      hi_d = hilo_wdata[63:32];
      lo_d = hilo_wdata[31:0];
    end else begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Issue controller for the shared 32x32 multiplier; sequences HI/LO moves,
// waits out the multiplier latency and commits the product into HI/LO.
module mul_hilo_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       mul_x_q, mul_x_d;
  logic [31:0]       mul_y_q, mul_y_d;
  logic              mul_signed_q, mul_signed_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              hi_we, lo_we, hilo_we;
  logic              accept;

  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  hilo_reg u_hilo (
    .clk        (clk),
    .reset      (reset),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (req_a),
    .hilo_we    (hilo_we),
    .hilo_wdata (mul_result),
    .hi         (hi),
    .lo         (lo)
  );

  // Flush overrides everything, including a commit that lands on the same edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_x_d      = mul_x_q;
    mul_y_d      = mul_y_q;
    mul_signed_d = mul_signed_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    hi_we        = 1'b0;
    lo_we        = 1'b0;
    hilo_we      = 1'b0;

    if (flush) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      rsp_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul_op(req_op)) begin
              mul_x_d      = req_a;
              mul_y_d      = req_b;
              mul_signed_d = (req_op == OP_MULT);
              cnt_d        = '0;
              state_d      = ST_MUL_WAIT;
            end else if (req_op == OP_MTHI) begin
              hi_we = 1'b1;
            end else if (req_op == OP_MTLO) begin
              lo_we = 1'b1;
            end else if ((req_op == OP_MFHI) || (req_op == OP_MFLO)) begin
              rsp_data_d  = (req_op == OP_MFHI) ? hi : lo;
              rsp_valid_d = 1'b1;
              state_d     = ST_RESP;
            end
          end
        end
        ST_MUL_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            hilo_we = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      mul_signed_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mul_x_q      <= mul_x_d;
      mul_y_q      <= mul_y_d;
      mul_signed_q <= mul_signed_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign mul_x      = mul_x_q;
  assign mul_y      = mul_y_q;
  assign mul_signed = mul_signed_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Bench for mul_hilo_ctrl: registered multiplier stand-in, directed cases and
// randomized traffic checked against a transaction-level HI/LO model.
module tb_mul_hilo_ctrl;
  import mul_ctrl_pkg::*;

  localparam int LAT = MUL_LAT_DEFAULT;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_rsp_data, m_mx, m_my;
  logic        m_rsp_valid, m_ms;
  logic [63:0] m_prod;
  int          m_mul_left;

  mul_hilo_ctrl #(.MUL_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_signed (mul_signed),
    .mul_result (mul_result),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-stage registered multiplier, matching the default latency
  always @(posedge clk) begin
    if (mul_signed)
      mul_result <= {{32{mul_x[31]}}, mul_x} * {{32{mul_y[31]}}, mul_y};
    else
      mul_result <= {32'b0, mul_x} * {32'b0, mul_y};
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic modelIdle();
    return (m_mul_left == 0) && !m_rsp_valid;
  endfunction

  task automatic modelReset();
    m_hi = '0; m_lo = '0; m_rsp_data = '0; m_mx = '0; m_my = '0;
    m_rsp_valid = 1'b0; m_ms = 1'b0; m_prod = '0; m_mul_left = 0;
  endtask

  task automatic modelStep(input logic v, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic fl, input logic rr, input logic rst);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (rst) begin
      modelReset();
    end else if (fl) begin
      m_mul_left  = 0;
      m_rsp_valid = 1'b0;
    end else if (m_mul_left > 0) begin
      m_mul_left--;
      if (m_mul_left == 0) begin
        m_hi = m_prod[63:32];
        m_lo = m_prod[31:0];
      end
    end else if (m_rsp_valid) begin
      if (rr) m_rsp_valid = 1'b0;
    end else if (v) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          if (op == OP_MULT) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            m_prod = 64'(sa * sb);
          end else begin
            ua = {32'b0, a};
            ub = {32'b0, b};
            m_prod = 64'(ua * ub);
          end
          m_mx = a; m_my = b; m_ms = (op == OP_MULT);
          m_mul_left = LAT + 1;
        end
        OP_MTHI: m_hi = a;
        OP_MTLO: m_lo = a;
        OP_MFHI: begin m_rsp_data = m_hi; m_rsp_valid = 1'b1; end
        OP_MFLO: begin m_rsp_data = m_lo; m_rsp_valid = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic checkState();
    checkOutput("hi", hi, m_hi);
    checkOutput("lo", lo, m_lo);
    checkOutput("rsp_valid", rsp_valid, m_rsp_valid);
    checkOutput("rsp_data", rsp_data, m_rsp_data);
    checkOutput("busy", busy, !modelIdle());
    checkOutput("mul_x", mul_x, m_mx);
    checkOutput("mul_y", mul_y, m_my);
    checkOutput("mul_signed", mul_signed, m_ms);
  endtask

  // Called at a negedge; drives one cycle and checks both sides of the edge.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic fl, input logic rr,
                               input logic rst);
    req_valid = v; req_op = op; req_a = a; req_b = b;
    flush = fl; rsp_ready = rr; reset = rst;
    #1;
    checkOutput("req_ready", req_ready, modelIdle() && !fl);
    @(posedge clk);
    modelStep(v, op, a, b, fl, rr, rst);
    #1;
    checkState();
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input logic rr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, OP_MFLO, 32'h0, 32'h0, 1'b0, rr, 1'b0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    req_valid = 0; req_op = 0; req_a = 0; req_b = 0;
    flush = 0; rsp_ready = 0; reset = 1;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    checkOutput("reset_req_ready", req_ready, 1'b1);
    checkState();
    @(negedge clk);

    // Signed multiply of -2 by 3
    applyStimulus(1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 1, 0);
    checkOutput("mult_signed_flag", mul_signed, 1'b1);
    idleCycles(2, 1'b1);
    checkOutput("mult_hi_lit", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo_lit", lo, 32'hFFFF_FFFA);

    // Unsigned max product, then MFHI held under back-pressure
    applyStimulus(1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0);
    idleCycles(2, 1'b1);
    checkOutput("multu_hi_lit", hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo_lit", lo, 32'h0000_0001);
    applyStimulus(1, OP_MFHI, 32'h0, 32'h0, 0, 0, 0);
    idleCycles(2, 1'b0);
    checkOutput("mfhi_held_valid", rsp_valid, 1'b1);
    checkOutput("mfhi_data_lit", rsp_data, 32'hFFFF_FFFE);
    idleCycles(1, 1'b1);
    checkOutput("mfhi_cleared", rsp_valid, 1'b0);

    // Back-to-back moves, then read LO
    applyStimulus(1, OP_MTHI, 32'h1234_5678, 32'h0, 0, 1, 0);
    applyStimulus(1, OP_MTLO, 32'h9ABC_DEF0, 32'h0, 0, 1, 0);
    checkOutput("mthi_lit", hi, 32'h1234_5678);
    applyStimulus(1, OP_MFLO, 32'h0, 32'h0, 0, 1, 0);
    checkOutput("mflo_data_lit", rsp_data, 32'h9ABC_DEF0);
    idleCycles(1, 1'b1);

    // Flush on the commit edge suppresses the write
    applyStimulus(0, OP_MFLO, 32'h0, 32'h0, 0, 1, 1);
    applyStimulus(1, OP_MULT, 32'd5, 32'd7, 0, 1, 0);
    idleCycles(1, 1'b1);
    applyStimulus(0, OP_MFLO, 32'h0, 32'h0, 1, 1, 0);
    checkOutput("flush_commit_hi", hi, 32'h0);
    checkOutput("flush_commit_lo", lo, 32'h0);
    checkOutput("flush_commit_busy", busy, 1'b0);

    // Flush while a request is offered in IDLE, then flush during RESP
    applyStimulus(1, OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1, 1, 0);
    checkOutput("flush_idle_hi", hi, 32'h0);
    applyStimulus(1, OP_MFHI, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(0, OP_MFLO, 32'h0, 32'h0, 1, 0, 0);
    checkOutput("flush_resp_valid", rsp_valid, 1'b0);

    // Reset in the middle of a multiply, then a fresh multiply
    applyStimulus(1, OP_MTHI, 32'hCAFE_0001, 32'h0, 0, 1, 0);
    applyStimulus(1, OP_MULT, 32'd9, 32'd9, 0, 1, 0);
    applyStimulus(0, OP_MFLO, 32'h0, 32'h0, 0, 1, 1);
    checkOutput("rst_mid_hi", hi, 32'h0);
    checkOutput("rst_mid_mul_x", mul_x, 32'h0);
    checkOutput("rst_mid_busy", busy, 1'b0);
    applyStimulus(1, OP_MULT, 32'd2, 32'd3, 0, 1, 0);
    idleCycles(2, 1'b1);
    checkOutput("post_rst_lo", lo, 32'd6);
    checkOutput("post_rst_hi", hi, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    3'($urandom_range(0, 7)),
                    pickOperand(), pickOperand(),
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
